// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR arbiter slice: FSM state encoding and
// default tap/seed constants for the common LFSR widths.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    DELIVER = 2'd2
  } state_e;

  localparam logic [0:3]  TAPS_L4  = 4'b1001;
  localparam logic [0:3]  SEED_L4  = 4'b1000;
  localparam logic [0:15] TAPS_L16 = 16'b0110100000000001;
  localparam logic [0:15] SEED_L16 = 16'hACE1;

endpackage

// File: rtl/lfsr.sv
// Generic LFSR, bit order [0:LENGTH-1]; Fibonacci shifts toward higher indices
// with feedback into bit 0, Galois rotates bit LENGTH-1 back through the taps.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int                TYPE   = 0,
  parameter int                EXTEND = 0,
  parameter int                LENGTH = 16,
  parameter logic [0:LENGTH-1] TAPS   = TAPS_L16,
  parameter logic [0:LENGTH-1] SEED   = SEED_L16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [0:LENGTH-1] state
);

  logic [0:LENGTH-1] r_state;
  logic [0:LENGTH-1] w_next;
  logic              w_fb;
  logic              w_low_zero;

  // Next-state logic; EXTEND splices the all-zero state into the Fibonacci cycle
  always_comb begin
    w_low_zero = (r_state[0:LENGTH-2] == {(LENGTH-1){1'b0}});
    w_fb       = (^(r_state & TAPS)) ^ ((EXTEND != 32'sd0) & w_low_zero);
    w_next     = r_state;
    if (TYPE == 32'sd0) begin
      w_next = {w_fb, r_state[0:LENGTH-2]};
    end else begin
      w_next[0] = r_state[LENGTH-1];
      for (int i = 1; i < LENGTH; i++) begin
        w_next[i] = r_state[i-1] ^ (TAPS[i] & r_state[LENGTH-1]);
      end
    end
  end

  // State register; only advances when enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEED;
    end else if (enable) begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule

// File: rtl/lfsr_rr_arbiter.sv
// Round-robin arbiter sharing one LFSR: each grant advances the sequence by
// STEPS states and then strobes the resulting word to the granted requester.
module lfsr_rr_arbiter
  import lfsr_pkg::*;
#(
  parameter int                NREQ   = 4,
  parameter int                LENGTH = 16,
  parameter logic [0:LENGTH-1] TAPS   = TAPS_L16,
  parameter int                TYPE   = 0,
  parameter logic [0:LENGTH-1] SEED   = SEED_L16,
  parameter int                STEPS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              word_valid,
  output logic [0:LENGTH-1] word
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(STEPS + 1);

  // First set request searching upward from l+1, wrapping modulo NREQ
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] l);
    logic [IW-1:0] sel;
    int            idx;
    sel = {IW{1'b0}};
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(l) + i) % NREQ;
      if (r[idx]) begin
        sel = IW'(idx);
      end
    end
    return sel;
  endfunction

  state_e          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [IW-1:0]   r_gidx, w_gidx_nxt;
  logic [IW-1:0]   w_pick;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_word_valid, w_valid_nxt;
  logic            w_lfsr_en;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_gidx_nxt  = r_gidx;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_valid_nxt = 1'b0;
    w_lfsr_en   = 1'b0;
    w_pick      = rr_pick(req, r_last);
    case (r_state)
      IDLE: begin
        if (req != {NREQ{1'b0}}) begin
          w_state_nxt = STEP;
          w_grant_nxt = NREQ'(1'b1) << w_pick;
          w_gidx_nxt  = w_pick;
          w_cnt_nxt   = CW'(STEPS);
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      STEP: begin
        w_lfsr_en = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_nxt = DELIVER;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      DELIVER: begin
        w_state_nxt = IDLE;
        w_grant_nxt = {NREQ{1'b0}};
        w_busy_nxt  = 1'b0;
        w_last_nxt  = r_gidx;
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = {NREQ{1'b0}};
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant      <= {NREQ{1'b0}};
      r_last       <= IW'(NREQ - 1);
      r_gidx       <= {IW{1'b0}};
      r_cnt        <= {CW{1'b0}};
      r_busy       <= 1'b0;
      r_word_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last       <= w_last_nxt;
      r_gidx       <= w_gidx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_busy       <= w_busy_nxt;
      r_word_valid <= w_valid_nxt;
    end
  end

  lfsr #(
    .TYPE   (TYPE),
    .EXTEND (0),
    .LENGTH (LENGTH),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (w_lfsr_en),
    .state  (word)
  );

  assign grant      = r_grant;
  assign busy       = r_busy;
  assign word_valid = r_word_valid;

endmodule

// File: tb/tb_lfsr_rr_arbiter.sv
// Directed bench for lfsr_rr_arbiter with LENGTH=4, TAPS=1001, SEED=1000;
// one instance with STEPS=2 and one with STEPS=1.
module tb_lfsr_rr_arbiter;

  logic       clk;
  logic       rst, rst1;
  logic [3:0] req, req1;
  logic [3:0] grant, grant1;
  logic       busy, busy1;
  logic       wv, wv1;
  logic [0:3] word, word1;
  int         checks;
  int         failures;

  lfsr_rr_arbiter #(
    .NREQ(4), .LENGTH(4), .TAPS(4'b1001), .TYPE(0), .SEED(4'b1000), .STEPS(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .busy(busy),
    .word_valid(wv), .word(word)
  );

  lfsr_rr_arbiter #(
    .NREQ(4), .LENGTH(4), .TAPS(4'b1001), .TYPE(0), .SEED(4'b1000), .STEPS(1)
  ) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .grant(grant1), .busy(busy1),
    .word_valid(wv1), .word(word1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One STEPS=2 transaction, entered in an IDLE cycle with req already set
  task automatic txn2(input logic [3:0] eg, input logic [3:0] ew);
    tick();
    check("grant_t1", grant, eg);
    check("busy_t1", busy, 1'b1);
    check("wv_t1", wv, 1'b0);
    tick();
    check("wv_t2", wv, 1'b0);
    tick();
    check("wv_deliver", wv, 1'b1);
    check("word_deliver", word, ew);
    check("grant_deliver", grant, eg);
    tick();
    check("wv_idle", wv, 1'b0);
    check("grant_idle", grant, 4'b0000);
    check("busy_idle", busy, 1'b0);
  endtask

  // One STEPS=1 transaction on the second instance
  task automatic txn1(input logic [3:0] eg, input logic [3:0] ew);
    tick();
    check("s1_grant", grant1, eg);
    check("s1_wv_step", wv1, 1'b0);
    tick();
    check("s1_wv_deliver", wv1, 1'b1);
    check("s1_word", word1, ew);
    tick();
    check("s1_wv_idle", wv1, 1'b0);
    check("s1_busy_idle", busy1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    rst1     = 1'b0;
    req      = 4'b1111;
    req1     = 4'b1111;

    // Reset held with all requests active
    tick();
    tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_wv", wv, 1'b0);
    check("rst_word", word, 4'b1000);
    check("rst1_word", word1, 4'b1000);
    check("rst1_grant", grant1, 4'b0000);

    // Idle with no requests: nothing advances
    req = 4'b0000;
    rst = 1'b1;
    tick();
    tick();
    tick();
    check("idle_busy", busy, 1'b0);
    check("idle_grant", grant, 4'b0000);
    check("idle_word", word, 4'b1000);

    // Single requester held high
    req = 4'b0001;
    txn2(4'b0001, 4'b1110);
    txn2(4'b0001, 4'b0111);
    txn2(4'b0001, 4'b0101);

    // All requesters: round-robin rotation
    req = 4'b0000;
    do_reset();
    req = 4'b1111;
    txn2(4'b0001, 4'b1110);
    txn2(4'b0010, 4'b0111);
    txn2(4'b0100, 4'b0101);
    txn2(4'b1000, 4'b1101);
    txn2(4'b0001, 4'b0011);

    // Sparse requests skip idle requesters
    req = 4'b0000;
    do_reset();
    req = 4'b1010;
    txn2(4'b0010, 4'b1110);
    txn2(4'b1000, 4'b0111);
    txn2(4'b0010, 4'b0101);

    // Reset in the second STEP cycle aborts without a strobe
    req = 4'b0000;
    do_reset();
    req = 4'b0001;
    tick();
    check("abort_grant_step1", grant, 4'b0001);
    tick();
    check("abort_busy_step2", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_grant", grant, 4'b0000);
    check("abort_busy", busy, 1'b0);
    check("abort_wv", wv, 1'b0);
    check("abort_word", word, 4'b1000);
    tick();
    check("abort_wv_hold", wv, 1'b0);
    rst = 1'b1;
    txn2(4'b0001, 4'b1110);

    // STEPS=1 instance
    req1 = 4'b0001;
    rst1 = 1'b1;
    txn1(4'b0001, 4'b1100);
    txn1(4'b0001, 4'b1110);
    txn1(4'b0001, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_rr_arbiter.md
# lfsr_rr_arbiter

Round-robin arbiter that shares one LFSR pseudo-random generator among NREQ requesters. Each grant advances the LFSR by exactly STEPS states, then delivers the resulting word to the granted requester with a one-cycle valid strobe. The LFSR sequence is continuous across grants, so requesters receive disjoint segments of one maximal-length sequence. It sits between the pseudo-random consumers (scramblers, test-pattern generators) and the single shared LFSR instance.

## Interface
- NREQ, 4: number of requesters, ≥1
- LENGTH, 16: LFSR width; bit order [0:LENGTH-1]
- TAPS, 16'b0110100000000001: tap mask passed to the LFSR
- TYPE, 0: 0 = Fibonacci, 1 = Galois; passed to the LFSR
- SEED, 16'hACE1: LFSR state loaded on reset; must be non-zero
- STEPS, 16: LFSR advances per grant, ≥1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  NREQ  level request, one bit per requester
- grant  out  NREQ  one-hot grant, held for the whole transaction
- busy  out  1  high while a transaction is in progress (STEP or DELIVER)
- word_valid  out  1  one-cycle strobe: word is valid for the granted requester
- word  out  [0:LENGTH-1]  current LFSR state, continuously driven

## Operation
- FSM states: IDLE, STEP, DELIVER.
- IDLE: if req != 0, select the first set bit searching upward from last+1, with modulo-NREQ wrap. Register grant one-hot, load step counter with STEPS, go to STEP. If req == 0, stay in IDLE.
- STEP: LFSR enable = 1 every cycle; counter decrements. On the cycle the counter equals 1, go to DELIVER.
- DELIVER: word_valid = 1 and LFSR enable = 0, so word is stable. Set last = granted index, clear grant, go to IDLE.
- Transactions are not abortable. If req drops during STEP, the transaction still completes and word_valid still pulses, and the word is consumed from the sequence.
- A requester that holds req high re-competes in the next IDLE cycle.
- LFSR enable is asserted only in STEP, so the sequence never advances outside grants.
- Counter width is $clog2(STEPS+1) and the counter never wraps.
- Reset values: state IDLE, grant 0, busy 0, word_valid 0, last NREQ-1 (requester 0 wins first), word = SEED (LFSR reset).
- Reset asserted mid-transaction: everything, including the LFSR, returns immediately to the reset values. The partially advanced sequence is lost and no word_valid is issued.

## Timing
- req sampled in the IDLE cycle at edge t. grant and busy are high from t+1. STEP occupies t+1 … t+STEPS. word_valid is high in cycle t+STEPS+1.
- Back-to-back throughput: one word per STEPS+2 cycles (IDLE, STEPS×STEP, DELIVER).
- grant and word_valid are registered. word is the LFSR register output, with no extra latency.
- Requests arriving during STEP or DELIVER are not seen until the next IDLE cycle. No requests are queued beyond the level-held req.

## Structure
- Shared package lfsr_pkg:
  - state enum typedef (IDLE, STEP, DELIVER)
  - default TAPS and SEED constants for LENGTH 4 and 16
- One sub-module: the existing LFSR module, instantiated once with TYPE, EXTEND=0, LENGTH, TAPS, seed=SEED, enable driven from the FSM, and rst/clk shared.
- The round-robin pick is a combinational function in the same file. No further sub-modules.

## Test plan
Unless stated otherwise, use LENGTH=4, TAPS=4'b1001, SEED=4'b1000, STEPS=2, NREQ=4.
- Reset: hold rst low with req=4'b1111 → grant=0, busy=0, word_valid=0, word=4'b1000.
- req=4'b0001 held high → grant=0001. word_valid every 4 cycles with word 1110, then 0111, then 0101. First word_valid 3 cycles after the sampling edge.
- req=4'b1111 held high → grant sequence 0001, 0010, 0100, 1000, 0001. Words 1110, 0111, 0101, 1101, 0011.
- req=4'b1010, first grant to requester 1 → next grant 1000, then 0010. No grant to requester 0 or 2.
- rst pulsed low in the second STEP cycle of the first grant → no word_valid. After release with req=0001, the first word is 1110 again.
- STEPS=1, req=0001 → word_valid every 3 cycles, words 1100, 1110, 1111.
